// File: rtl/out_fifo_rd_sched.sv
// Read-side scheduler for a bank of OUT_FIFO byte lanes: lock-step draining,
// lane-skew detection and per-lane flush.
module out_fifo_rd_sched #(
    parameter int NUM_LANES    = 4,
    parameter int PRIME_CYCLES = 2,
    parameter int SKEW_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 flush,
    input  logic [NUM_LANES-1:0] empty,
    output logic [NUM_LANES-1:0] rden,
    output logic                 valid,
    output logic                 skew_err,
    output logic                 busy,
    output logic [15:0]          rd_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_DRAIN = 3'd2,
        S_ERR   = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic        run_reg;
    logic [3:0]  prime_cnt_reg, prime_cnt_next;
    logic [7:0]  skew_cnt_reg, skew_cnt_next;
    logic [8:0]  skew_inc;
    logic        skew_err_reg, skew_err_next;
    logic        valid_reg;
    logic [15:0] rd_count_reg, rd_count_next;

    logic all_rdy, all_emp, part, aligned_rd;

    assign all_rdy    = ~|empty;
    assign all_emp    = &empty;
    assign part       = ~all_rdy & ~all_emp;
    assign aligned_rd = (state_reg == S_DRAIN) && all_rdy;
    assign skew_inc   = {1'b0, skew_cnt_reg} + 9'd1;

    // run_reg holds the FSM still for the first edge after reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_reg       <= 1'b0;
            state_reg     <= S_IDLE;
            prime_cnt_reg <= '0;
            skew_cnt_reg  <= '0;
            skew_err_reg  <= 1'b0;
            valid_reg     <= 1'b0;
            rd_count_reg  <= '0;
        end else begin
            run_reg       <= 1'b1;
            state_reg     <= state_next;
            prime_cnt_reg <= prime_cnt_next;
            skew_cnt_reg  <= skew_cnt_next;
            skew_err_reg  <= skew_err_next;
            valid_reg     <= aligned_rd;
            rd_count_reg  <= rd_count_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        prime_cnt_next = prime_cnt_reg;
        skew_cnt_next  = skew_cnt_reg;
        skew_err_next  = skew_err_reg;
        rd_count_next  = rd_count_reg;
        if (run_reg) begin
            rd_count_next = rd_count_reg + 16'(aligned_rd);
            if (flush) begin
                state_next     = S_FLUSH;
                prime_cnt_next = '0;
                skew_cnt_next  = '0;
                skew_err_next  = 1'b0;
                rd_count_next  = '0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (en && all_rdy) begin
                            state_next     = S_PRIME;
                            prime_cnt_next = 4'd1;
                        end
                    end
                    S_PRIME: begin
                        if (!en || !all_rdy) begin
                            state_next     = S_IDLE;
                            prime_cnt_next = '0;
                        end else if (prime_cnt_reg == 4'(PRIME_CYCLES)) begin
                            state_next     = S_DRAIN;
                            prime_cnt_next = '0;
                        end else begin
                            prime_cnt_next = prime_cnt_reg + 4'd1;
                        end
                    end
                    S_DRAIN: begin
                        if (all_rdy)
                            skew_cnt_next = '0;
                        // a read issued together with ~en still completes; only the FSM leaves
                        if (!en || all_emp) begin
                            state_next    = S_IDLE;
                            skew_cnt_next = '0;
                        end else if (part) begin
                            skew_cnt_next = skew_inc[7:0];
                            if (skew_inc == 9'(SKEW_TIMEOUT)) begin
                                state_next    = S_ERR;
                                skew_err_next = 1'b1;
                            end
                        end
                    end
                    S_ERR: begin
                        state_next = S_ERR;
                    end
                    S_FLUSH: begin
                        if (all_emp)
                            state_next = S_IDLE;
                    end
                    default: begin
                        state_next = S_IDLE;
                    end
                endcase
            end
        end
    end

    // rden depends only on state and live EMPTY, so it never strobes an empty lane
    always_comb begin
        rden = '0;
        case (state_reg)
            S_DRAIN: rden = {NUM_LANES{all_rdy}};
            S_FLUSH: rden = ~empty;
            default: rden = '0;
        endcase
        busy = (state_reg != S_IDLE);
    end

    assign valid    = valid_reg;
    assign skew_err = skew_err_reg;
    assign rd_count = rd_count_reg;

endmodule

// File: tb/tb_out_fifo_rd_sched.sv
// Self-checking bench for out_fifo_rd_sched: behavioural OUT_FIFO lanes feed a
// scoreboard of aligned words that is compared whenever VALID is seen.
module tb_out_fifo_rd_sched;

    localparam int NL = 4;
    localparam int PC = 2;
    localparam int TO = 8;
    localparam logic [NL-1:0] ALL_F = '1;
    localparam logic [NL-1:0] FL_MASK = 4'b1011;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en;
    logic          flush;
    logic [NL-1:0] empty;
    logic [NL-1:0] rden;
    logic          valid;
    logic          skew_err;
    logic          busy;
    logic [15:0]   rd_count;

    int               wr_ptr[NL] = '{default: 0};
    int               rd_ptr[NL] = '{default: 0};
    logic [8*NL-1:0]  q_word = '0;
    logic [8*NL-1:0]  exp_q[$];
    int               errors = 0;
    int               checks = 0;
    int               valid_cnt = 0;
    bit               quiet = 1'b0;

    out_fifo_rd_sched #(
        .NUM_LANES   (NL),
        .PRIME_CYCLES(PC),
        .SKEW_TIMEOUT(TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .flush   (flush),
        .empty   (empty),
        .rden    (rden),
        .valid   (valid),
        .skew_err(skew_err),
        .busy    (busy),
        .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lane_byte(int lane, int p);
        return 8'((p * 7 + lane * 61 + 3) & 255);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else if (!quiet) begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Behavioural OUT_FIFO lanes: data appears on Q one cycle after RDEN
    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
        assign empty[gi] = (wr_ptr[gi] == rd_ptr[gi]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (rden[i] && !empty[i]) begin
                q_word[8*i +: 8] <= lane_byte(i, rd_ptr[i]);
                rd_ptr[i]        <= rd_ptr[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if ((rden & empty) != '0)
            check("rden_into_empty", 64'(rden & empty), 64'(0));
        if (valid === 1'b1) begin
            valid_cnt++;
            if (exp_q.size() == 0)
                check("valid_without_data", 64'(valid), 64'(0));
            else
                check("rd_data", 64'(q_word), 64'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_all(input int n);
        logic [8*NL-1:0] e;
        for (int k = 0; k < n; k++) begin
            e = '0;
            for (int i = 0; i < NL; i++) begin
                e[8*i +: 8] = lane_byte(i, wr_ptr[i]);
                wr_ptr[i]++;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic write_lanes(input logic [NL-1:0] mask, input int n);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < NL; i++)
                if (mask[i]) wr_ptr[i]++;
    endtask

    task automatic count_until_rden(input logic [NL-1:0] val, input string tag, output int n);
        n = 0;
        tick();
        while (rden !== val && n < 50) begin
            n++;
            tick();
        end
        if (rden !== val)
            check({tag, "_timeout"}, 64'(rden), 64'(val));
    endtask

    task automatic count_while_rden(input logic [NL-1:0] val, output int n);
        n = 0;
        while (rden === val && n < 70000) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0;
        en      = 1'b0;
        flush   = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        check("rst_rden", 64'(rden), 64'(0));
        check("rst_valid", 64'(valid), 64'(0));
        check("rst_skew_err", 64'(skew_err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rd_count", 64'(rd_count), 64'(0));

        // 1: basic aligned drain
        write_all(5);
        en = 1'b1;
        count_until_rden(ALL_F, "t1_prime", n);
        check("t1_prime_cycles", 64'(n), 64'(PC));
        count_while_rden(ALL_F, n);
        check("t1_drain_reads", 64'(n), 64'(5));
        tick();
        check("t1_busy", 64'(busy), 64'(0));
        check("t1_rd_count", 64'(rd_count), 64'(5));
        check("t1_valid_cnt", 64'(valid_cnt), 64'(5));

        // 2: lane 2 runs dry while the others hold data
        en = 1'b0;
        write_all(2);
        write_lanes(FL_MASK, 5);
        en = 1'b1;
        count_until_rden(ALL_F, "t2_prime", n);
        check("t2_prime_cycles", 64'(n), 64'(PC));
        count_while_rden(ALL_F, n);
        check("t2_drain_reads", 64'(n), 64'(2));
        n = 0;
        while (!skew_err && n < 50) begin
            check("t2_rden_stalled", 64'(rden), 64'(0));
            n++;
            tick();
        end
        check("t2_skew_cycles", 64'(n), 64'(TO));
        repeat (4) tick();
        check("t2_skew_err_hold", 64'(skew_err), 64'(1));
        check("t2_err_busy", 64'(busy), 64'(1));
        check("t2_err_rden", 64'(rden), 64'(0));
        check("t2_rd_count", 64'(rd_count), 64'(7));

        // 3: flush out of ERR
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t3_skew_err", 64'(skew_err), 64'(0));
        check("t3_rd_count", 64'(rd_count), 64'(0));
        check("t3_rden", 64'(rden), 64'(FL_MASK));
        count_while_rden(FL_MASK, n);
        check("t3_flush_reads", 64'(n), 64'(5));
        tick();
        check("t3_busy", 64'(busy), 64'(0));

        // 4: EN dropped mid-drain with 3 words left
        write_all(6);
        count_until_rden(ALL_F, "t4_prime", n);
        check("t4_prime_cycles", 64'(n), 64'(PC));
        n = 0;
        while (rd_count != 16'd3 && n < 50) begin
            n++;
            tick();
        end
        check("t4_rden_before_drop", 64'(rden), 64'(ALL_F));
        en = 1'b0;
        tick();
        check("t4_rd_count", 64'(rd_count), 64'(4));
        check("t4_busy", 64'(busy), 64'(0));
        for (int k = 0; k < 3; k++) begin
            check("t4_rden_after", 64'(rden), 64'(0));
            tick();
        end

        // 5: RD_COUNT wrap
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            n++;
            tick();
        end
        exp_q.delete();
        check("t5_flushed_busy", 64'(busy), 64'(0));
        check("t5_rd_count_clr", 64'(rd_count), 64'(0));
        quiet = 1'b1;
        write_all(65536);
        en = 1'b1;
        n = 0;
        while (rd_count != 16'hFFFF && n < 70000) begin
            n++;
            tick();
        end
        quiet = 1'b0;
        check("t5_reach_ffff", 64'(rd_count), 64'hFFFF);
        check("t5_last_rden", 64'(rden), 64'(ALL_F));
        tick();
        check("t5_wrap", 64'(rd_count), 64'(0));
        tick();
        check("t5_busy", 64'(busy), 64'(0));

        // 6: async reset mid-drain
        en = 1'b0;
        write_all(6);
        en = 1'b1;
        count_until_rden(ALL_F, "t6_prime", n);
        repeat (2) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rden_rst", 64'(rden), 64'(0));
        check("t6_valid_rst", 64'(valid), 64'(0));
        check("t6_busy_rst", 64'(busy), 64'(0));
        check("t6_rd_count_rst", 64'(rd_count), 64'(0));
        tick();
        reset_n = 1'b1;
        count_until_rden(ALL_F, "t6_reprime", n);
        check("t6_reprime_cycles", 64'(n), 64'(PC + 1));
        count_while_rden(ALL_F, n);
        check("t6_drain_reads", 64'(n), 64'(4));
        repeat (3) tick();
        check("t6_busy", 64'(busy), 64'(0));
        check("t6_rd_count", 64'(rd_count), 64'(4));
        check("sb_leftover", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
